// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the pushbutton conditioning logic.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS_CHK   = 2'd1,
      HELD        = 2'd2,
      RELEASE_CHK = 2'd3
   } btn_state_t;

   function automatic int cnt_width(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_pulse_gen_if.sv
// Button-side signal bundle: raw input in, debounced level and edge pulses out.
interface btn_pulse_gen_if;

   logic btn_in;
   logic btn_db;
   logic press_pulse;
   logic release_pulse;

   modport master (
      input  btn_in,
      output btn_db,
      output press_pulse,
      output release_pulse
   );

   modport slave (
      output btn_in,
      input  btn_db,
      input  press_pulse,
      input  release_pulse
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reused for other panel inputs.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic q_reg;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         meta_reg <= RESET_VAL;
         q_reg    <= RESET_VAL;
      end else begin
         meta_reg <= d;
         q_reg    <= meta_reg;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/btn_pulse_gen.sv
// Debounces a raw pushbutton into a level plus one-cycle press/release pulses.
// Define BTN_AUTO_REPEAT_EN to add hold-to-repeat press pulses while HELD.
module btn_pulse_gen
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit ACTIVE_LOW      = 1'b0,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 5000000
) (
   input logic             clk,
   input logic             clr,
   btn_pulse_gen_if.master bus
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   generate
      if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
         $error("btn_pulse_gen: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
      end
   endgenerate

   btn_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             db_reg, db_next;
   logic             press_reg, press_next;
   logic             release_reg, release_next;
   logic             sync_q;
   logic             s;
   logic             rep_fire;

   sync_2ff #(.RESET_VAL(ACTIVE_LOW)) u_sync (
      .clk (clk),
      .clr (clr),
      .d   (bus.btn_in),
      .q   (sync_q)
   );

   assign s = ACTIVE_LOW ? ~sync_q : sync_q;

`ifdef BTN_AUTO_REPEAT_EN
   localparam int REP_W = cnt_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));

   logic [REP_W-1:0] rep_cnt_reg;
   logic             rep_phase_reg;
   logic [REP_W-1:0] rep_last;

   // Phase 0 waits out the initial hold delay, phase 1 produces the steady repeat.
   assign rep_last = rep_phase_reg ? REP_W'(REPEAT_CYCLES - 1) : REP_W'(HOLD_CYCLES - 1);
   assign rep_fire = (state_reg == HELD) && s && (rep_cnt_reg == rep_last);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rep_cnt_reg   <= '0;
         rep_phase_reg <= 1'b0;
      end else if (state_reg != HELD || !s) begin
         rep_cnt_reg   <= '0;
         rep_phase_reg <= 1'b0;
      end else if (rep_fire) begin
         rep_cnt_reg   <= '0;
         rep_phase_reg <= 1'b1;
      end else begin
         rep_cnt_reg   <= rep_cnt_reg + 1'b1;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         db_reg      <= 1'b0;
         press_reg   <= 1'b0;
         release_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         db_reg      <= db_next;
         press_reg   <= press_next;
         release_reg <= release_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      press_next   = 1'b0;
      release_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (s) begin
               state_next = PRESS_CHK;
               cnt_next   = '0;
            end
         end
         PRESS_CHK: begin
            if (!s) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = HELD;
               cnt_next   = '0;
               press_next = 1'b1;
            end else begin
               cnt_next   = cnt_reg + 1'b1;
            end
         end
         HELD: begin
            if (!s) begin
               state_next = RELEASE_CHK;
               cnt_next   = '0;
            end else if (rep_fire) begin
               press_next = 1'b1;
            end
         end
         RELEASE_CHK: begin
            if (s) begin
               state_next   = HELD;
               cnt_next     = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next   = IDLE;
               cnt_next     = '0;
               release_next = 1'b1;
            end else begin
               cnt_next     = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
      // Level tracks the next state so it moves on the same edge as its pulse.
      db_next = (state_next == HELD) || (state_next == RELEASE_CHK);
   end

   assign bus.btn_db        = db_reg;
   assign bus.press_pulse   = press_reg;
   assign bus.release_pulse = release_reg;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Scoreboard bench for btn_pulse_gen at DEBOUNCE_CYCLES=4 (active-high and active-low instances).
module tb_btn_pulse_gen;

   localparam int DB  = 4;
   localparam int HLD = 10;
   localparam int REP = 5;
   localparam int LAT = DB + 2;   // edges after the first sampled edge
`ifdef BTN_AUTO_REPEAT_EN
   localparam bit AUTO_REP = 1'b1;
`else
   localparam bit AUTO_REP = 1'b0;
`endif

   typedef struct {
      int cyc;
      bit is_press;
   } ev_t;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   ev_t  exp_q[$];

   btn_pulse_gen_if bus();
   btn_pulse_gen_if al_bus();

   btn_pulse_gen #(
      .DEBOUNCE_CYCLES (DB),
      .ACTIVE_LOW      (1'b0),
      .HOLD_CYCLES     (HLD),
      .REPEAT_CYCLES   (REP)
   ) u_dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   btn_pulse_gen #(
      .DEBOUNCE_CYCLES (DB),
      .ACTIVE_LOW      (1'b1),
      .HOLD_CYCLES     (HLD),
      .REPEAT_CYCLES   (REP)
   ) u_dut_al (
      .clk (clk),
      .clr (clr),
      .bus (al_bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every pulse seen must match the oldest expected event.
   always @(negedge clk) begin
      if (bus.press_pulse || bus.release_pulse) begin
         ev_t e;
         total++;
         if (bus.press_pulse && bus.release_pulse) begin
            bad++;
            $display("FAIL both_pulses: cyc=%0d press=1 release=1, required at most one", cyc);
         end else if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: cyc=%0d press=%0d release=%0d, required none",
                     cyc, bus.press_pulse, bus.release_pulse);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc !== cyc || e.is_press !== bus.press_pulse) begin
               bad++;
               $display("FAIL pulse_event: got cyc=%0d press=%0d, required cyc=%0d press=%0d",
                        cyc, bus.press_pulse, e.cyc, e.is_press);
            end
         end
         total++;
         if (bus.btn_db !== bus.press_pulse) begin
            bad++;
            $display("FAIL db_with_pulse: cyc=%0d btn_db=%0d, required %0d",
                     cyc, bus.btn_db, bus.press_pulse);
         end
      end
   end

   task automatic push_ev(input int c, input bit p);
      ev_t e;
      e.cyc      = c;
      e.is_press = p;
      exp_q.push_back(e);
   endtask

   task automatic push_repeats(input int entry, input int leave);
      int t;
      if (AUTO_REP) begin
         t = entry + HLD;
         while (t < leave) begin
            push_ev(t, 1'b1);
            t += REP;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({bus.btn_db, bus.press_pulse, bus.release_pulse} !== 3'b000) begin
         bad++;
         $display("FAIL reset_outputs: got %b, required 000",
                  {bus.btn_db, bus.press_pulse, bus.release_pulse});
      end
      total++;
      if ({al_bus.btn_db, al_bus.press_pulse, al_bus.release_pulse} !== 3'b000) begin
         bad++;
         $display("FAIL reset_outputs_al: got %b, required 000",
                  {al_bus.btn_db, al_bus.press_pulse, al_bus.release_pulse});
      end
      clr = 1'b0;
      repeat (10) @(negedge clk);
      total++;
      if (bus.btn_db !== 1'b0) begin
         bad++;
         $display("FAIL idle_db: got %0d, required 0", bus.btn_db);
      end
   endtask

   task automatic test_clean_press();
      int e1;
      bus.btn_in = 1'b1;
      e1 = cyc + 1;
      push_ev(e1 + LAT, 1'b1);
      push_repeats(e1 + LAT, e1 + 20 + 2);
      push_ev(e1 + 20 + LAT, 1'b0);
      repeat (20) @(negedge clk);
      total++;
      if (bus.btn_db !== 1'b1) begin
         bad++;
         $display("FAIL clean_held_db: got %0d, required 1", bus.btn_db);
      end
      bus.btn_in = 1'b0;
      repeat (12) @(negedge clk);
      total++;
      if (exp_q.size() !== 0) begin
         bad++;
         $display("FAIL clean_pending: got %0d events outstanding, required 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_press_bounce();
      for (int k = 0; k < 20; k++) begin
         bus.btn_in = ((k % 5) < 3);
         @(negedge clk);
         total++;
         if (bus.btn_db !== 1'b0) begin
            bad++;
            $display("FAIL bounce_db: step=%0d got %0d, required 0", k, bus.btn_db);
         end
      end
      bus.btn_in = 1'b0;
      repeat (10) @(negedge clk);
      total++;
      if (bus.btn_db !== 1'b0) begin
         bad++;
         $display("FAIL bounce_final_db: got %0d, required 0", bus.btn_db);
      end
   endtask

   task automatic test_release_bounce();
      int e1;
      int d0;
      bus.btn_in = 1'b1;
      e1 = cyc + 1;
      push_ev(e1 + LAT, 1'b1);
      repeat (10) @(negedge clk);
      bus.btn_in = 1'b0;
      d0 = cyc + 1;
      push_repeats(e1 + LAT, d0 + 2);
      push_ev(d0 + 5 + LAT, 1'b0);
      repeat (2) @(negedge clk);
      bus.btn_in = 1'b1;
      repeat (3) @(negedge clk);
      bus.btn_in = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      total++;
      if (bus.btn_db !== 1'b1) begin
         bad++;
         $display("FAIL release_chk_db: got %0d, required 1", bus.btn_db);
      end
      repeat (8) @(negedge clk);
      total++;
      if (exp_q.size() !== 0 || bus.btn_db !== 1'b0) begin
         bad++;
         $display("FAIL release_done: got pending=%0d db=%0d, required pending=0 db=0",
                  exp_q.size(), bus.btn_db);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int e1;
      bus.btn_in = 1'b1;
      repeat (5) @(negedge clk);
      clr = 1'b1;
      #1;
      total++;
      if ({bus.btn_db, bus.press_pulse, bus.release_pulse} !== 3'b000) begin
         bad++;
         $display("FAIL mid_reset_outputs: got %b, required 000",
                  {bus.btn_db, bus.press_pulse, bus.release_pulse});
      end
      repeat (3) @(negedge clk);
      clr = 1'b0;
      e1 = cyc + 1;
      push_ev(e1 + LAT, 1'b1);
      push_repeats(e1 + LAT, e1 + 15 + 2);
      push_ev(e1 + 15 + LAT, 1'b0);
      repeat (15) @(negedge clk);
      bus.btn_in = 1'b0;
      repeat (12) @(negedge clk);
      total++;
      if (exp_q.size() !== 0) begin
         bad++;
         $display("FAIL mid_reset_pending: got %0d events outstanding, required 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_active_low();
      int e1;
      int n_press;
      int n_rel;
      int p_cyc;
      n_press = 0;
      n_rel   = 0;
      p_cyc   = -1;
      al_bus.btn_in = 1'b0;
      e1 = cyc + 1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (al_bus.press_pulse) begin
            n_press++;
            p_cyc = cyc;
         end
      end
      total++;
      if (n_press !== 1 || p_cyc !== e1 + LAT) begin
         bad++;
         $display("FAIL al_press: got count=%0d cyc=%0d, required count=1 cyc=%0d",
                  n_press, p_cyc, e1 + LAT);
      end
      total++;
      if (al_bus.btn_db !== 1'b1) begin
         bad++;
         $display("FAIL al_db: got %0d, required 1", al_bus.btn_db);
      end
      al_bus.btn_in = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (al_bus.release_pulse) n_rel++;
      end
      total++;
      if (n_rel !== 1 || al_bus.btn_db !== 1'b0) begin
         bad++;
         $display("FAIL al_release: got count=%0d db=%0d, required count=1 db=0",
                  n_rel, al_bus.btn_db);
      end
   endtask

   task automatic test_hold();
      int e1;
      bus.btn_in = 1'b1;
      e1 = cyc + 1;
      push_ev(e1 + LAT, 1'b1);
      push_repeats(e1 + LAT, e1 + 34 + 2);
      push_ev(e1 + 34 + LAT, 1'b0);
      repeat (34) @(negedge clk);
      bus.btn_in = 1'b0;
      repeat (12) @(negedge clk);
      total++;
      if (exp_q.size() !== 0) begin
         bad++;
         $display("FAIL hold_pending: got %0d events outstanding, required 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   initial begin
      bus.btn_in    = 1'b0;
      al_bus.btn_in = 1'b1;
      test_reset();
      test_clean_press();
      test_press_bounce();
      test_release_bounce();
      test_reset_mid();
      test_active_low();
      test_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
